// File: rtl/operand_loader.sv
// Debounces two push-buttons and, on each debounced press, loads the synchronized switch value
// as an operand for a downstream comparator, tracking which operands have been supplied.
module operand_loader #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1_raw,
  input  logic       btn2_raw,
  input  logic [3:0] sw_in,
  output logic [3:0] in,
  output logic       push1,
  output logic       push2,
  output logic       both_loaded,
  output logic [7:0] load_count
);

  typedef enum logic [1:0] {StEmpty, StHave1, StHave2, StBoth} state_e;

  logic [1:0]      btn_s1_q, btn_s2_q;
  logic [3:0]      sw_s1_q, sw_s2_q;
  logic [1:0]      db_q, db_d, db_dly_q;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      push_q, push_d;
  logic [3:0]      in_q, in_d;
  state_e          state_q, state_d;
  logic            both_q, both_d;
  logic [7:0]      count_q, count_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == db_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
        // This sample completes the mismatch run: accept the new level.
        db_d[i]  = ~db_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    push_d  = db_q & ~db_dly_q;
    in_d    = in_q;
    state_d = state_q;
    count_d = count_q;
    if (|push_d) begin
      in_d = sw_s2_q;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
    unique case (state_q)
      StEmpty: begin
        if (push_d == 2'b11)      state_d = StBoth;
        else if (push_d == 2'b01) state_d = StHave1;
        else if (push_d == 2'b10) state_d = StHave2;
      end
      StHave1: if (push_d[1]) state_d = StBoth;
      StHave2: if (push_d[0]) state_d = StBoth;
      StBoth:  state_d = StBoth;
      default: state_d = StEmpty;
    endcase
    both_d = (state_d == StBoth);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '0;
      push_q   <= '0;
      in_q     <= '0;
      state_q  <= StEmpty;
      both_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      btn_s1_q <= {btn2_raw, btn1_raw};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      push_q   <= push_d;
      in_q     <= in_d;
      state_q  <= state_d;
      both_q   <= both_d;
      count_q  <= count_d;
    end
  end

  assign in          = in_q;
  assign push1       = push_q[0];
  assign push2       = push_q[1];
  assign both_loaded = both_q;
  assign load_count  = count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized and directed bench for operand_loader, checked against a history-window model.
module tb_operand_loader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1_raw = 1'b0, btn2_raw = 1'b0;
  logic [3:0] sw_in = 4'h0;
  logic [3:0] in;
  logic       push1, push2, both_loaded;
  logic [7:0] load_count;

  int n_checks = 0;
  int n_fail = 0;
  int seen1 = 0, seen2 = 0;

  operand_loader #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn1_raw(btn1_raw), .btn2_raw(btn2_raw), .sw_in(sw_in),
    .in(in), .push1(push1), .push2(push2), .both_loaded(both_loaded), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a button's accepted level flips once the last DB synchronized samples
  // all disagree with it; a strobe follows one edge after each accepted rise.
  logic [1:0]   m_b1, m_b2;
  logic [3:0]   m_sw1, m_sw2;
  bit           m_db[2];
  bit           m_pend[2];
  logic [255:0] m_hist[2];
  bit           m_push1, m_push2, m_have1, m_have2, m_both;
  logic [3:0]   m_in;
  int           m_cnt;

  function automatic bit all_differ(input logic [255:0] h, input bit lvl);
    for (int k = 0; k < int'(DB); k++) if (h[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b1 = '0; m_b2 = '0; m_sw1 = '0; m_sw2 = '0;
      for (int i = 0; i < 2; i++) begin
        m_db[i] = 0; m_pend[i] = 0; m_hist[i] = '0;
      end
      m_push1 = 0; m_push2 = 0; m_have1 = 0; m_have2 = 0; m_both = 0; m_in = '0; m_cnt = 0;
    end else begin
      m_push1 = m_pend[0];
      m_push2 = m_pend[1];
      if (m_push1 || m_push2) begin
        m_in = m_sw2;
        if (m_cnt < 255) m_cnt++;
      end
      m_have1 |= m_push1;
      m_have2 |= m_push2;
      m_both = m_have1 && m_have2;
      for (int i = 0; i < 2; i++) begin
        m_hist[i] = {m_hist[i][254:0], m_b2[i]};
        m_pend[i] = 0;
        if (all_differ(m_hist[i], m_db[i])) begin
          m_db[i]   = ~m_db[i];
          m_pend[i] = m_db[i];
        end
      end
      m_b2 = m_b1; m_b1 = {btn2_raw, btn1_raw};
      m_sw2 = m_sw1; m_sw1 = sw_in;
    end
  end

  always @(negedge clk) begin
    check_eq("push1", push1, m_push1);
    check_eq("push2", push2, m_push2);
    check_eq("in", in, m_in);
    check_eq("both_loaded", both_loaded, m_both);
    check_eq("load_count", load_count, m_cnt);
    if (push1) seen1++;
    if (push2) seen2++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn1_raw = 1'b0; btn2_raw = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Runs n edges after the current drive point; returns the edge index of the first strobe.
  task automatic watch(input int n, input int which, output int first);
    first = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (first < 0 && ((which == 1) ? push1 : push2)) first = k;
    end
    #1;
  endtask

  initial begin
    int e, e2, s1, s2;
    rst_n = 1'b0;
    repeat (2) tick();
    check_eq("reset_in", in, 4'h0);
    check_eq("reset_cnt", load_count, 8'd0);
    check_eq("reset_push", {push1, push2, both_loaded}, 3'b000);
    rst_n = 1'b1;

    // Clean press of button 1.
    tick();
    sw_in = 4'hA; btn1_raw = 1'b1; s1 = seen1;
    watch(12, 1, e);
    check_eq("b1_edge", e, DB + 2);
    check_eq("b1_count", seen1 - s1, 1);
    check_eq("b1_in", in, 4'hA);
    check_eq("b1_lc", load_count, 8'd1);
    btn1_raw = 1'b0;
    repeat (10) tick();

    // Bouncy button 2.
    do_reset();
    tick();
    sw_in = 4'h3; s2 = seen2;
    btn2_raw = 1'b1; tick(); btn2_raw = 1'b0; tick(); btn2_raw = 1'b1; tick();
    tick(); btn2_raw = 1'b0; tick(); btn2_raw = 1'b1;
    watch(16, 2, e);
    check_eq("bounce_edge", e, DB + 2);
    check_eq("bounce_count", seen2 - s2, 1);
    check_eq("bounce_in", in, 4'h3);

    // Simultaneous presses.
    do_reset();
    tick();
    sw_in = 4'h5; btn1_raw = 1'b1; btn2_raw = 1'b1; s1 = seen1; s2 = seen2;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (push1 || push2) check_eq("simul_pair", {push1, push2}, 2'b11);
    end
    #1;
    check_eq("simul_n1", seen1 - s1, 1);
    check_eq("simul_n2", seen2 - s2, 1);
    check_eq("simul_in", in, 4'h5);
    check_eq("simul_both", both_loaded, 1'b1);
    check_eq("simul_lc", load_count, 8'd1);

    // Long hold, release, re-press.
    do_reset();
    s1 = seen1;
    btn1_raw = 1'b1; repeat (100) tick();
    btn1_raw = 1'b0; repeat (20) tick();
    btn1_raw = 1'b1; repeat (20) tick();
    check_eq("hold_strobes", seen1 - s1, 2);
    btn1_raw = 1'b0; repeat (10) tick();

    // Reset during a strobe, button held through it.
    do_reset();
    tick();
    sw_in = 4'h9; btn1_raw = 1'b1;
    watch(7, 1, e);
    check_eq("mid_push_seen", e, DB + 2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_push1", push1, 1'b0);
    check_eq("rst_in", in, 4'h0);
    check_eq("rst_lc", load_count, 8'd0);
    check_eq("rst_both", both_loaded, 1'b0);
    tick(); tick();
    rst_n = 1'b1; s1 = seen1;
    watch(14, 1, e2);
    check_eq("rst_fresh_edge", e2, DB + 2);
    check_eq("rst_fresh_n", seen1 - s1, 1);
    btn1_raw = 1'b0; repeat (10) tick();

    // Free-running random toggling, model-checked every cycle.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) btn1_raw = ~btn1_raw;
      if ($urandom_range(0, 5) == 0) btn2_raw = ~btn2_raw;
      sw_in = 4'($urandom);
      tick();
    end
    btn1_raw = 1'b0; btn2_raw = 1'b0;

    // 300 bouncy press/release cycles to saturate the counter.
    do_reset();
    s1 = seen1; s2 = seen2;
    for (int p = 0; p < 300; p++) begin
      bit b;
      b = 1'($urandom);
      sw_in = 4'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        if (b) btn2_raw = 1'($urandom); else btn1_raw = 1'($urandom);
        tick();
      end
      if (b) btn2_raw = 1'b1; else btn1_raw = 1'b1;
      repeat ($urandom_range(7, 10)) tick();
      btn1_raw = 1'b0; btn2_raw = 1'b0;
      repeat ($urandom_range(7, 10)) tick();
    end
    check_eq("sat_strobes", (seen1 - s1) + (seen2 - s2), 300);
    check_eq("sat_lc", load_count, 8'd255);
    check_eq("sat_both", both_loaded, m_have1 && m_have2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive synchronized samples required to accept a button level change (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 btn1_raw  input  1  raw, bouncy push-button requesting load of operand 1.
REQ-005 btn2_raw  input  1  raw, bouncy push-button requesting load of operand 2.
REQ-006 sw_in  input  4  raw switch value to be loaded.
REQ-007 in  output  4  registered operand value presented to the downstream 4-bit comparator.
REQ-008 push1  output  1  one-cycle strobe: downstream captures in as operand 1.
REQ-009 push2  output  1  one-cycle strobe: downstream captures in as operand 2.
REQ-010 both_loaded  output  1  high once both operands have been pushed since reset.
REQ-011 load_count  output  8  number of strobe events issued since reset, saturating.

Function
REQ-012 Each raw button and each sw_in bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each button SHALL have an independent debouncer: stable level db, counter cnt; cnt clears whenever synchronized sample equals db; cnt increments on each mismatching sample.
REQ-014 db SHALL toggle, and cnt clear, on the edge at which the DB_CYCLES-th consecutive mismatching sample is taken.
REQ-015 A mismatch run interrupted by even one matching sample SHALL restart from cnt=0 (glitch rejection).
REQ-016 pushN SHALL assert for exactly one cycle on the edge after dbN rises; no strobe on db falling edge.
REQ-017 Latency: raw button stable high from before edge 0 -> dbN toggles at edge DB_CYCLES+1 -> pushN high from edge DB_CYCLES+2 to edge DB_CYCLES+3.
REQ-018 Holding a button indefinitely SHALL produce exactly one strobe; a new strobe requires release (debounced) then re-press.
REQ-019 in SHALL update only on the edge a strobe asserts, taking synchronized sw_in at that edge; in is held stable for the whole strobe cycle and thereafter.
REQ-020 If push1 and push2 would assert on the same edge, both SHALL assert together with a single in value.
REQ-021 State machine states EMPTY, HAVE1, HAVE2, BOTH: EMPTY->HAVE1 on push1 only, EMPTY->HAVE2 on push2 only, EMPTY->BOTH on simultaneous strobes; HAVE1->BOTH on push2; HAVE2->BOTH on push1; BOTH is absorbing until reset; repeat strobes of an already-held operand keep the state.
REQ-022 both_loaded SHALL be a registered decode of state==BOTH, rising on the edge the state enters BOTH.
REQ-023 load_count SHALL increment by 1 per strobe edge (simultaneous push1+push2 counts 1), saturating at 255.

Reset
REQ-024 While rst_n low: synchronizers 0, db 0, cnt 0, in=4'h0, push1=push2=0, state EMPTY, both_loaded=0, load_count=0.
REQ-025 Reset assertion mid-debounce or mid-strobe SHALL immediately force all outputs low/zero; a button still held at deassertion SHALL produce one strobe after full REQ-017 latency.

Verification
REQ-026 DB_CYCLES=4, sw_in=4'hA, btn1_raw clean high from edge 0 -> push1 high between edges 6 and 7 only, in=4'hA from edge 6, state HAVE1, load_count=1.
REQ-027 btn2_raw bounces 1,0,1,1,0 then stable 1, sw_in=4'h3 -> exactly one push2, issued DB_CYCLES+2 edges after the last bounce, in=4'h3.
REQ-028 btn1_raw and btn2_raw rise on the same edge, sw_in=4'h5 -> push1 and push2 high in the same cycle, in=4'h5, EMPTY->BOTH, both_loaded=1, load_count=1.
REQ-029 Button held 100 cycles then released and re-pressed -> exactly two strobes total, none on release.
REQ-030 rst_n pulsed low during push1 cycle -> push1, in, load_count, both_loaded immediately 0; held button yields one fresh strobe after deassertion.
REQ-031 300 press/release cycles -> load_count reaches 255 and holds at 255.
